// File: rtl/arcanoid_pkg.sv
// Shared constants and state encoding for the Arkanoid game-flow logic.
// Screen geometry and the lose line are also used by draw_ball_y and
// collision_detector, so they live here rather than in one module.
package arcanoid_pkg;

   localparam int unsigned STATE_W         = 3;
   localparam int unsigned LIVES_W         = 3;
   localparam int unsigned CNT_W           = 8;
   localparam int unsigned YPOS_W          = 12;

   localparam int unsigned SCREEN_W        = 1024;
   localparam int unsigned SCREEN_H        = 768;
   localparam int unsigned LOSE_Y_DEF      = 760;
   localparam int unsigned BLOCK_COUNT_DEF = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_COUNT = 3'd2,
      ST_PLAY  = 3'd3,
      ST_LOST  = 3'd4,
      ST_WIN   = 3'd5,
      ST_OVER  = 3'd6,
      ST_PAUSE = 3'd7
   } state_e;

endpackage

// File: rtl/arcanoid_edge_sync.sv
// Optional N-stage synchroniser followed by a registered rising-edge pulse.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset
//   d_i     - raw level input
//   pulse_o - one-cycle pulse, registered, on each rising edge of d_i
// STAGES=0 skips the synchroniser for inputs already in the clk_i domain.
module arcanoid_edge_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic pulse_o
);

   logic level;
   logic prev_q;

   generate
      if (STAGES == 0) begin : g_nosync
         assign level = d_i;
      end else begin : g_sync
         logic [STAGES-1:0] sync_q;
         // Shift chain; element 0 is the metastability-exposed flop.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= d_i;
               for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end
         assign level = sync_q[STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q  <= 1'b0;
         pulse_o <= 1'b0;
      end else begin
         prev_q  <= level;
         pulse_o <= level & ~prev_q;
      end
   end

endmodule

// File: rtl/arcanoid_game_ctl.sv
// Game-flow sequencer: holds, runs or freezes the ball, counts lives and
// triggers block-field reloads. Optional pause when ARCANOID_PAUSE_EN is
// defined (adds pause_req input and the PAUSE state).
// Ports:
//   pclk, reset        - pixel clock, asynchronous active-high reset
//   mouse_left         - raw left button (foreign clock domain)
//   vblnk              - vertical blank; its rising edge is the frame tick
//   ball_y_pos         - ball y coordinate
//   blocks_in          - alive-block bitmap
//   pause_req          - pause toggle request (ARCANOID_PAUSE_EN only)
//   state              - encoded game state
//   ball_run/ball_hold - ball movement / ball pinned to paddle
//   ball_serve         - pulse: reload ball to serve position
//   blocks_reload      - pulse: restore all blocks
//   lives              - remaining lives
module arcanoid_game_ctl
   import arcanoid_pkg::*;
#(
   parameter int unsigned LIVES_INIT   = 3,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned LOST_FRAMES  = 90,
   parameter int unsigned LOSE_Y       = LOSE_Y_DEF,
   parameter int unsigned BLOCK_COUNT  = BLOCK_COUNT_DEF
) (
   input  logic                   pclk,
   input  logic                   reset,
   input  logic                   mouse_left,
   input  logic                   vblnk,
   input  logic [YPOS_W-1:0]      ball_y_pos,
   input  logic [BLOCK_COUNT-1:0] blocks_in,
`ifdef ARCANOID_PAUSE_EN
   input  logic                   pause_req,
`endif
   output logic [STATE_W-1:0]     state,
   output logic                   ball_run,
   output logic                   ball_hold,
   output logic                   ball_serve,
   output logic                   blocks_reload,
   output logic [LIVES_W-1:0]     lives
);

   logic click;
   logic frame_tick;

   arcanoid_edge_sync #(.STAGES(2)) u_click (
      .clk_i(pclk), .rst_i(reset), .d_i(mouse_left), .pulse_o(click));

   arcanoid_edge_sync #(.STAGES(0)) u_frame (
      .clk_i(pclk), .rst_i(reset), .d_i(vblnk), .pulse_o(frame_tick));

`ifdef ARCANOID_PAUSE_EN
   logic pause_tick;
   arcanoid_edge_sync #(.STAGES(0)) u_pause (
      .clk_i(pclk), .rst_i(reset), .d_i(pause_req), .pulse_o(pause_tick));
`endif

   state_e             state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               serve_q, serve_d;
   logic               reload_q, reload_d;
   logic               run_q, run_d;
   logic               hold_q, hold_d;

   // State and registered outputs.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         lives_q  <= LIVES_W'(LIVES_INIT);
         cnt_q    <= '0;
         serve_q  <= 1'b0;
         reload_q <= 1'b0;
         run_q    <= 1'b0;
         hold_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         lives_q  <= lives_d;
         cnt_q    <= cnt_d;
         serve_q  <= serve_d;
         reload_q <= reload_d;
         run_q    <= run_d;
         hold_q   <= hold_d;
      end
   end

   // Next state; the counter is cleared on every state change.
   always_comb begin
      state_d  = state_q;
      lives_d  = lives_q;
      cnt_d    = cnt_q;
      serve_d  = 1'b0;
      reload_d = 1'b0;
      case (state_q)
         ST_SERVE: begin
            if (click) begin
               state_d = ST_COUNT;
               cnt_d   = '0;
            end
         end
         ST_COUNT: begin
            if (frame_tick) begin
               if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                  state_d = ST_PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_PLAY: begin
            // Win beats lose; both beat a pause request.
            if (blocks_in == '0) begin
               state_d = ST_WIN;
               cnt_d   = '0;
            end else if (ball_y_pos >= YPOS_W'(LOSE_Y)) begin
               state_d = ST_LOST;
               cnt_d   = '0;
               if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
            end
`ifdef ARCANOID_PAUSE_EN
            else if (pause_tick) begin
               state_d = ST_PAUSE;
               cnt_d   = '0;
            end
`endif
         end
         ST_LOST: begin
            if (frame_tick) begin
               if (cnt_q == CNT_W'(LOST_FRAMES - 1)) begin
                  cnt_d = '0;
                  if (lives_q != '0) begin
                     state_d = ST_SERVE;
                     serve_d = 1'b1;
                  end else begin
                     state_d = ST_OVER;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_WIN, ST_OVER: begin
            if (click) begin
               state_d  = ST_SERVE;
               cnt_d    = '0;
               serve_d  = 1'b1;
               reload_d = 1'b1;
               lives_d  = LIVES_W'(LIVES_INIT);
            end
         end
`ifdef ARCANOID_PAUSE_EN
         ST_PAUSE: begin
            if (pause_tick) begin
               state_d = ST_PLAY;
               cnt_d   = '0;
            end
         end
`endif
         // IDLE, and state 7 when pause is not built in.
         default: begin
            state_d  = ST_SERVE;
            cnt_d    = '0;
            serve_d  = 1'b1;
            reload_d = 1'b1;
         end
      endcase
      run_d  = (state_d == ST_PLAY);
      hold_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) || (state_d == ST_COUNT);
   end

   assign state         = state_q;
   assign lives         = lives_q;
   assign ball_serve    = serve_q;
   assign blocks_reload = reload_q;
   assign ball_run      = run_q;
   assign ball_hold     = hold_q;

endmodule

// File: tb/tb_arcanoid_game_ctl.sv
// Directed bench for arcanoid_game_ctl. Define ARCANOID_PAUSE_EN to also
// exercise the pause path.
module tb_arcanoid_game_ctl;

   logic        pclk;
   logic        reset;
   logic        mouse_left;
   logic        vblnk;
   logic [11:0] ball_y_pos;
   logic [15:0] blocks_in;
`ifdef ARCANOID_PAUSE_EN
   logic        pause_req;
`endif
   logic [2:0]  state;
   logic        ball_run;
   logic        ball_hold;
   logic        ball_serve;
   logic        blocks_reload;
   logic [2:0]  lives;

   int n_chk  = 0;
   int n_pass = 0;

   arcanoid_game_ctl dut (
      .pclk          (pclk),
      .reset         (reset),
      .mouse_left    (mouse_left),
      .vblnk         (vblnk),
      .ball_y_pos    (ball_y_pos),
      .blocks_in     (blocks_in),
`ifdef ARCANOID_PAUSE_EN
      .pause_req     (pause_req),
`endif
      .state         (state),
      .ball_run      (ball_run),
      .ball_hold     (ball_hold),
      .ball_serve    (ball_serve),
      .blocks_reload (blocks_reload),
      .lives         (lives)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Advance n edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   // One vblnk rise; the FSM acts on it at the second edge.
   task automatic frame();
      vblnk = 1'b1;
      tick(1);
      vblnk = 1'b0;
      tick(1);
   endtask

   // Button rise sampled at edge N; state changes at N+3.
   task automatic click_now();
      mouse_left = 1'b1;
      tick(4);
      mouse_left = 1'b0;
   endtask

   // From SERVE: click, then SERVE_FRAMES frame ticks into PLAY.
   task automatic go_play(input string tag);
      click_now();
      chk({tag, " count"}, state, 2);
      repeat (60) frame();
      chk({tag, " play"}, state, 3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b1;
      mouse_left = 1'b0;
      vblnk      = 1'b0;
      ball_y_pos = 12'd0;
      blocks_in  = 16'hFFFF;
`ifdef ARCANOID_PAUSE_EN
      pause_req  = 1'b0;
`endif
      tick(3);
      chk("rst state", state, 0);
      chk("rst lives", lives, 3);
      chk("rst hold", ball_hold, 1);
      chk("rst run", ball_run, 0);
      chk("rst serve", ball_serve, 0);
      chk("rst reload", blocks_reload, 0);

      reset = 1'b0;
      tick(1);
      chk("idle->serve state", state, 1);
      chk("idle serve pulse", ball_serve, 1);
      chk("idle reload pulse", blocks_reload, 1);
      chk("serve hold", ball_hold, 1);
      tick(1);
      chk("serve pulse end", ball_serve, 0);
      chk("reload pulse end", blocks_reload, 0);

      // Blocks outside PLAY are ignored.
      blocks_in = 16'h0000;
      tick(3);
      chk("blocks ign serve", state, 1);
      blocks_in = 16'h00F0;

      // Click latency: no change at N+2, COUNT at N+3.
      mouse_left = 1'b1;
      tick(3);
      chk("click N+2", state, 1);
      tick(1);
      chk("click N+3", state, 2);
      mouse_left = 1'b0;
      repeat (59) frame();
      chk("count 59", state, 2);
      frame();
      chk("count 60 play", state, 3);
      chk("play run", ball_run, 1);
      chk("play hold", ball_hold, 0);

      // Three losses: lives 3->2->1->0, then game over.
      for (int l = 0; l < 3; l++) begin
         ball_y_pos = 12'd760;
         tick(1);
         chk("lost state", state, 4);
         chk("lost lives", lives, 2 - l);
         chk("lost run", ball_run, 0);
         chk("lost hold", ball_hold, 0);
         ball_y_pos = 12'd100;
         if (l == 0) begin
            click_now();
            chk("click ign lost", state, 4);
         end
         repeat (89) frame();
         chk("lost 89", state, 4);
         frame();
         if (l < 2) begin
            chk("reserve state", state, 1);
            chk("reserve pulse", ball_serve, 1);
            chk("reserve no reload", blocks_reload, 0);
            tick(1);
            chk("reserve pulse end", ball_serve, 0);
            go_play("relaunch");
         end else begin
            chk("over state", state, 6);
            chk("over lives", lives, 0);
         end
      end

      click_now();
      chk("restart state", state, 1);
      chk("restart lives", lives, 3);
      chk("restart reload", blocks_reload, 1);
      chk("restart serve", ball_serve, 1);
      tick(1);
      go_play("g2");

      // One loss so the win check sees a non-initial lives value.
      ball_y_pos = 12'd761;
      tick(1);
      chk("g2 lost lives", lives, 2);
      ball_y_pos = 12'd0;
      repeat (90) frame();
      chk("g2 reserve", state, 1);
      go_play("g3");

      // Win and lose together: win has priority, lives kept.
      ball_y_pos = 12'd759;
      tick(2);
      chk("y 759 stays", state, 3);
      blocks_in  = 16'h0000;
      ball_y_pos = 12'd800;
      tick(1);
      chk("win state", state, 5);
      chk("win lives", lives, 2);
      blocks_in  = 16'hFFFF;
      ball_y_pos = 12'd0;
      click_now();
      chk("win->serve", state, 1);
      chk("win restart lives", lives, 3);
      chk("win reload", blocks_reload, 1);
      tick(1);

      // Async reset mid-COUNT (counter at 30), away from any edge.
      click_now();
      repeat (30) frame();
      chk("mid count", state, 2);
      #2;
      reset = 1'b1;
      #1;
      chk("async rst state", state, 0);
      chk("async rst hold", ball_hold, 1);
      chk("async rst lives", lives, 3);
      tick(2);
      reset = 1'b0;
      tick(1);
      chk("post rst serve", state, 1);
      chk("post rst pulse", ball_serve, 1);
      tick(1);
      go_play("post rst");

`ifdef ARCANOID_PAUSE_EN
      pause_req = 1'b1;
      tick(2);
      chk("pause state", state, 7);
      chk("pause run", ball_run, 0);
      chk("pause hold", ball_hold, 0);
      pause_req = 1'b0;
      click_now();
      chk("click ign pause", state, 7);
      pause_req = 1'b1;
      tick(2);
      chk("unpause state", state, 3);
      chk("unpause run", ball_run, 1);
      pause_req = 1'b0;
      tick(1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
